// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencer issuing credit-gated imem requests,
// tracking in-flight PCs, queueing responses and flushing on branch.
module fetch_stage #(
  parameter int unsigned    PCW      = 32,
  parameter int unsigned    INSTW    = 32,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             branch,
  input  logic [PCW-1:0]   branch_pc,
  output logic             imem_req,
  output logic [PCW-1:0]   imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [INSTW-1:0] imem_rdata,
  output logic             inst_valid,
  output logic [INSTW-1:0] inst_out,
  output logic [PCW-1:0]   pc_out,
  input  logic             inst_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [PCW-1:0]   pc_q, pc_d;
  logic             hold_q, hold_d;
  logic [1:0]       drop_q, drop_d;

  logic [PCW-1:0]   if_pc_q [2];
  logic [PCW-1:0]   if_pc_d [2];
  logic             if_wr_q, if_wr_d;
  logic             if_rd_q, if_rd_d;
  logic [1:0]       if_cnt_q, if_cnt_d;

  logic [PCW-1:0]   oq_pc_q [2];
  logic [PCW-1:0]   oq_pc_d [2];
  logic [INSTW-1:0] oq_in_q [2];
  logic [INSTW-1:0] oq_in_d [2];
  logic             oq_wr_q, oq_wr_d;
  logic             oq_rd_q, oq_rd_d;
  logic [1:0]       oq_cnt_q, oq_cnt_d;

  logic             grant;
  logic             rsp;
  logic             keep;
  logic             pop;
  logic [2:0]       used;
  logic             credit;

  // Handshake decode, credit check and head-of-queue outputs
  always_comb begin
    rsp        = imem_rvalid & (if_cnt_q != 2'd0);
    keep       = rsp & (state_q == RUN) & ~branch;
    inst_valid = (oq_cnt_q != 2'd0) & ~branch;
    pop        = inst_valid & inst_ready;
    used       = 3'(if_cnt_q) + 3'(oq_cnt_q) - 3'(pop);
    credit     = used < 3'd2;
    imem_req   = (state_q == RUN) & enable & ~branch
               & (credit | hold_q);
    grant      = imem_req & imem_gnt;
    imem_addr  = pc_q;
    inst_out   = '0;
    pc_out     = '0;
    if (oq_cnt_q != 2'd0) begin
      inst_out = oq_in_q[oq_rd_q];
      pc_out   = oq_pc_q[oq_rd_q];
    end
  end

  // Fetch PC advance/redirect and request hold until granted
  always_comb begin
    pc_d   = pc_q;
    hold_d = imem_req & ~imem_gnt;
    if (grant) begin
      pc_d = pc_q + PCW'(4);
    end
    if (branch) begin
      pc_d = branch_pc;
    end
  end

  // In-flight PC FIFO: push on grant, pop on any valid response
  always_comb begin
    if_pc_d  = if_pc_q;
    if_wr_d  = if_wr_q;
    if_rd_d  = if_rd_q;
    if_cnt_d = if_cnt_q;
    if (grant) begin
      if_pc_d[if_wr_q] = pc_q;
      if_wr_d          = ~if_wr_q;
    end
    if (rsp) begin
      if_rd_d = ~if_rd_q;
    end
    unique case ({grant, rsp})
      2'b10:   if_cnt_d = if_cnt_q + 2'd1;
      2'b01:   if_cnt_d = if_cnt_q - 2'd1;
      default: if_cnt_d = if_cnt_q;
    endcase
  end

  // Output queue: push kept responses, pop on consume, clear on branch
  always_comb begin
    oq_pc_d  = oq_pc_q;
    oq_in_d  = oq_in_q;
    oq_wr_d  = oq_wr_q;
    oq_rd_d  = oq_rd_q;
    oq_cnt_d = oq_cnt_q;
    if (keep) begin
      oq_pc_d[oq_wr_q] = if_pc_q[if_rd_q];
      oq_in_d[oq_wr_q] = imem_rdata;
      oq_wr_d          = ~oq_wr_q;
    end
    if (pop) begin
      oq_rd_d = ~oq_rd_q;
    end
    unique case ({keep, pop})
      2'b10:   oq_cnt_d = oq_cnt_q + 2'd1;
      2'b01:   oq_cnt_d = oq_cnt_q - 2'd1;
      default: oq_cnt_d = oq_cnt_q;
    endcase
    if (branch) begin
      oq_wr_d  = 1'b0;
      oq_rd_d  = 1'b0;
      oq_cnt_d = 2'd0;
    end
  end

  // Next state and stale-response drop counter
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (rsp && state_q == FLUSH && drop_q != 2'd0) begin
      drop_d = drop_q - 2'd1;
    end
    if (branch) begin
      drop_d = if_cnt_d;
    end
    unique case (state_q)
      IDLE: begin
        if (enable && !branch) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (branch) begin
          if (if_cnt_d != 2'd0) begin
            state_d = FLUSH;
          end
        end else if (!enable && if_cnt_q == 2'd0) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (drop_d == 2'd0) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      hold_q   <= 1'b0;
      drop_q   <= 2'd0;
      if_pc_q  <= '{default: '0};
      if_wr_q  <= 1'b0;
      if_rd_q  <= 1'b0;
      if_cnt_q <= 2'd0;
      oq_pc_q  <= '{default: '0};
      oq_in_q  <= '{default: '0};
      oq_wr_q  <= 1'b0;
      oq_rd_q  <= 1'b0;
      oq_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
      if_pc_q  <= if_pc_d;
      if_wr_q  <= if_wr_d;
      if_rd_q  <= if_rd_d;
      if_cnt_q <= if_cnt_d;
      oq_pc_q  <= oq_pc_d;
      oq_in_q  <= oq_in_d;
      oq_wr_q  <= oq_wr_d;
      oq_rd_q  <= oq_rd_d;
      oq_cnt_q <= oq_cnt_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PCW, default 32, PC and address width; matches the execute stage PC width.
REQ-002 Parameter INSTW, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  fetch permitted; the block leaves IDLE only while high.
REQ-007 branch  input  1  taken-branch redirect; driven by execute branch_out.
REQ-008 branch_pc  input  PCW  redirect target; driven by execute PC_out.
REQ-009 imem_req  output  1  instruction memory request valid.
REQ-010 imem_addr  output  PCW  request address.
REQ-011 imem_gnt  input  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  input  1  response data valid; responses return in request order.
REQ-013 imem_rdata  input  INSTW  response instruction.
REQ-014 inst_valid  output  1  head instruction available to decode.
REQ-015 inst_out  output  INSTW  head instruction.
REQ-016 pc_out  output  PCW  PC of the head instruction.
REQ-017 inst_ready  input  1  decode consumes the head this cycle.

Function
REQ-018 The state machine SHALL have the states IDLE, RUN and FLUSH, and SHALL reset to IDLE.
REQ-019 IDLE->RUN SHALL occur when enable=1; RUN->IDLE SHALL occur when enable=0 and outstanding=0; RUN->FLUSH SHALL occur when branch=1 and outstanding (after this cycle's grant/response) >0; FLUSH->RUN SHALL occur when drop_cnt reaches 0.
REQ-020 The fetch PC register SHALL advance by 4 on each grant (imem_req & imem_gnt), wrapping modulo 2^PCW.
REQ-021 imem_addr SHALL equal the fetch PC register, and imem_req SHALL be asserted only in RUN, with enable=1 and branch=0, and only when outstanding + queue_count < 2.
REQ-022 imem_req SHALL be held high with a stable imem_addr until granted, except where it is withdrawn by branch or by enable=0.
REQ-023 A 2-entry in-flight FIFO SHALL record the PC of each granted request; outstanding (0..2) SHALL be that FIFO's occupancy.
REQ-024 A 2-entry output queue SHALL store {pc, instruction}; on a non-dropped imem_rvalid it SHALL push {head in-flight PC, imem_rdata}. Credit gating guarantees this push never overflows.
REQ-025 inst_valid SHALL equal (queue_count != 0) and branch=0; inst_out and pc_out SHALL show the queue head; a pop SHALL occur when inst_valid & inst_ready.
REQ-026 Minimum latency SHALL be: grant in cycle N with rvalid in N+1 gives inst_valid in N+2; sustained throughput SHALL be 1 instruction/cycle while imem_gnt=1, rvalid follows in 1 cycle and inst_ready=1.
REQ-027 When branch=1, in any state, the block SHALL:
  - load the fetch PC with branch_pc;
  - clear the output queue, ignoring any same-cycle pop;
  - set drop_cnt to the number of in-flight requests that are still outstanding after this cycle's grant/response;
  - treat any response arriving in the branch cycle as stale.
REQ-028 In FLUSH, each imem_rvalid SHALL decrement drop_cnt and pop the in-flight FIFO without pushing the queue; no requests SHALL issue.
REQ-029 A branch during FLUSH SHALL reload the PC and recompute drop_cnt; a branch in IDLE SHALL load the PC and remain in IDLE.
REQ-030 An imem_rvalid with outstanding=0 is a protocol error; it SHALL be ignored and SHALL NOT corrupt any counter.
REQ-031 A push and a pop in the same cycle SHALL leave queue_count unchanged, and a grant and a response in the same cycle SHALL leave outstanding unchanged.

Reset
REQ-032 While rst_n=0, asynchronously: state=IDLE, fetch PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, pc_out=0, queue, in-flight FIFO and drop_cnt all 0.
REQ-033 Reset asserted mid-operation SHALL discard all queued and in-flight state. Responses to pre-reset requests are not expected after reset.
REQ-034 The first request SHALL issue no earlier than the first rising edge after rst_n deasserts and enable=1.

Verification
REQ-035 Stream: RESET_PC=0, enable=1, gnt=1, 1-cycle memory, inst_ready=1 -> addresses 0,4,8,C, and pc_out 0,4,8 with matching data from cycle 2, one per cycle.
REQ-036 Backpressure: inst_ready=0 -> exactly 2 entries are queued, imem_req drops, and head pc_out=0 is held; inst_ready=1 -> drains in order 0,4, then fetch resumes at 8.
REQ-037 Redirect with 2 outstanding (requests to 8 and C): branch=1, branch_pc=0x100 -> FLUSH; the next 2 responses are dropped, then imem_addr=0x100 and the first pc_out=0x100.
REQ-038 Redirect with queue_count=2 and a same-cycle inst_ready=1 -> queue emptied, no pop delivered, inst_valid=0 in the branch cycle.
REQ-039 Grant stall: gnt=0 for 3 cycles -> imem_req stays high with imem_addr stable at 4, and no PC advance.
REQ-040 Reset mid-stream at PC=0x20 -> all outputs return to reset values immediately; after release, the next request is to RESET_PC.
